// File: rtl/membus_arbiter_if.sv
// Requester-side bus of the BRAM arbiter: one instance per requester (CPU, DMA).
interface membus_arbiter_if #(
  parameter int unsigned ADDR_W = 14
);
  logic              req;
  logic              lock;
  logic [3:0]        we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;

  // Requester drives the access, arbiter answers with grant and read data.
  modport master (
    output req, lock, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, lock, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/membus_arbiter.sv
// membus_arbiter: shares the BRAM data port between the CPU load/store path and a
// DMA requester. Round-robin arbitration with an optional bounded burst lock; the
// granted access is registered onto the BRAM port and read data returns two cycles
// after the grant to the requester that issued it.
module membus_arbiter #(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  membus_arbiter_if.slave   cpu,
  membus_arbiter_if.slave   dma,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic       IdCpu    = 1'b0;
  localparam logic       IdDma    = 1'b1;
  localparam logic [8:0] MaxBurst = 9'(MAX_BURST);

  // Arbitration state
  logic       last;
  logic       lock_act;
  logic       owner;
  logic [7:0] beats;
  logic       last_d;
  logic       lock_act_d;
  logic       owner_d;
  logic [7:0] beats_d;

  // Read-tag pipeline: stage 1 aligns with mem_*, stage 2 with mem_rdata
  logic rd_v1;
  logic rd_id1;
  logic rd_v2;
  logic rd_id2;

  logic [1:0]        req;
  logic [1:0]        lck;
  logic              gnt_any;
  logic              gnt_id;
  logic              g_lock;
  logic [3:0]        g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [31:0]       g_wdata;
  logic              cpu_rv;
  logic              dma_rv;

  assign req = {dma.req, cpu.req};
  assign lck = {dma.lock, cpu.lock};

  // Grant choice: a live burst owner goes first, otherwise alternate against last.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = IdCpu;
    if (lock_act && req[owner] && ({1'b0, beats} < MaxBurst)) begin
      gnt_any = 1'b1;
      gnt_id  = owner;
    end else if (req[0] && req[1]) begin
      gnt_any = 1'b1;
      gnt_id  = ~last;
    end else if (req[0]) begin
      gnt_any = 1'b1;
      gnt_id  = IdCpu;
    end else if (req[1]) begin
      gnt_any = 1'b1;
      gnt_id  = IdDma;
    end
  end

  // Payload of the granted requester.
  always_comb begin
    if (gnt_id == IdDma) begin
      g_lock  = dma.lock;
      g_we    = dma.we;
      g_addr  = dma.addr;
      g_wdata = dma.wdata;
    end else begin
      g_lock  = cpu.lock;
      g_we    = cpu.we;
      g_addr  = cpu.addr;
      g_wdata = cpu.wdata;
    end
  end

  // Burst-lock and last-grant next state.
  always_comb begin
    last_d     = last;
    lock_act_d = lock_act;
    owner_d    = owner;
    beats_d    = beats;
    // Owner walking away ends its burst even without a grant this cycle.
    if (lock_act && !req[owner]) begin
      lock_act_d = 1'b0;
      beats_d    = 8'd0;
    end
    if (gnt_any) begin
      last_d = gnt_id;
      if (g_lock && (!lock_act || (owner != gnt_id))) begin
        lock_act_d = 1'b1;
        owner_d    = gnt_id;
        beats_d    = 8'd1;
      end else if (g_lock) begin
        beats_d = beats + 8'd1;
      end else begin
        lock_act_d = 1'b0;
        beats_d    = 8'd0;
      end
      // Exhausted burst releases so the other side wins the next contention.
      if (lock_act_d && ({1'b0, beats_d} >= MaxBurst)) begin
        lock_act_d = 1'b0;
        beats_d    = 8'd0;
      end
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last     <= IdDma;
      lock_act <= 1'b0;
      owner    <= IdCpu;
      beats    <= 8'd0;
    end else begin
      last     <= last_d;
      lock_act <= lock_act_d;
      owner    <= owner_d;
      beats    <= beats_d;
    end
  end

  // Registered BRAM port; address and data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 4'd0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
    end else if (gnt_any) begin
      mem_en    <= 1'b1;
      mem_we    <= g_we;
      mem_addr  <= g_addr;
      mem_wdata <= g_wdata;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 4'd0;
    end
  end

  // Read-tag pipeline; reset drops any read still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v1  <= 1'b0;
      rd_id1 <= IdCpu;
      rd_v2  <= 1'b0;
      rd_id2 <= IdCpu;
    end else begin
      rd_v1  <= gnt_any && (g_we == 4'd0);
      rd_id1 <= gnt_id;
      rd_v2  <= rd_v1;
      rd_id2 <= rd_id1;
    end
  end

  assign cpu_rv = rd_v2 && (rd_id2 == IdCpu);
  assign dma_rv = rd_v2 && (rd_id2 == IdDma);

  assign cpu.gnt    = rst_n && gnt_any && (gnt_id == IdCpu);
  assign dma.gnt    = rst_n && gnt_any && (gnt_id == IdDma);
  assign cpu.rvalid = cpu_rv;
  assign dma.rvalid = dma_rv;
  assign cpu.rdata  = cpu_rv ? mem_rdata : 32'd0;
  assign dma.rdata  = dma_rv ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_membus_arbiter.sv
// Bench for membus_arbiter: directed scenarios plus random traffic, checked by a
// reference model that predicts grants, BRAM port accesses and read returns.
module tb_membus_arbiter;

  localparam int MaxBurst = 4;

  typedef struct {
    int          stamp;
    logic [13:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
  } mem_t;

  typedef struct {
    int          stamp;
    int          id;
    logic [31:0] data;
  } rd_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;

  membus_arbiter_if #(.ADDR_W(14)) cpu_if ();
  membus_arbiter_if #(.ADDR_W(14)) dma_if ();

  membus_arbiter #(
    .ADDR_W   (14),
    .MAX_BURST(MaxBurst)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu      (cpu_if),
    .dma      (dma_if),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  mem_t mem_q[$];
  rd_t  rd_q[$];

  logic [31:0] bram    [64];
  logic [31:0] ref_mem [64];

  // Reference arbitration state
  int last_id  = 1;
  int b_owner  = -1;
  int b_left   = 0;
  int last_gnt = -1;
  int dut_g    = -1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // BRAM model driven by the DUT's registered port.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == 4'd0) mem_rdata <= bram[mem_addr[5:0]];
      else bram[mem_addr[5:0]] = merge(bram[mem_addr[5:0]], mem_wdata, mem_we);
    end
  end

  task automatic set_req(int i, logic r, logic l, logic [3:0] we, logic [13:0] a,
                         logic [31:0] d);
    if (i == 0) begin
      cpu_if.req = r; cpu_if.lock = l; cpu_if.we = we; cpu_if.addr = a; cpu_if.wdata = d;
    end else begin
      dma_if.req = r; dma_if.lock = l; dma_if.we = we; dma_if.addr = a; dma_if.wdata = d;
    end
  endtask

  task automatic rand_req(int i);
    logic [3:0] we;
    we = ($urandom % 2 == 0) ? 4'd0 : 4'($urandom % 16);
    set_req(i, ($urandom % 4) != 0, ($urandom % 3) == 0, we, 14'($urandom % 64), $urandom);
  endtask

  // Predict this cycle's grant from the arbitration rules and queue its effects.
  task automatic model_and_check();
    logic [1:0]  r;
    logic [1:0]  l;
    logic [3:0]  we;
    logic [13:0] a;
    logic [31:0] d;
    int          g;
    mem_t        m;
    rd_t         e;
    r = {dma_if.req, cpu_if.req};
    l = {dma_if.lock, cpu_if.lock};
    g = -1;
    dut_g = cpu_if.gnt ? 0 : (dma_if.gnt ? 1 : -1);
    if (!rst_n) begin
      last_id = 1; b_owner = -1; b_left = 0;
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
    end else begin
      if (b_owner >= 0 && r[b_owner] && b_left > 0) g = b_owner;
      else if (r[0] && r[1]) g = 1 - last_id;
      else if (r[0]) g = 0;
      else if (r[1]) g = 1;
      if (b_owner >= 0 && !r[b_owner]) b_owner = -1;
      if (g >= 0) begin
        if (l[g]) begin
          if (b_owner != g) begin
            b_owner = g;
            b_left  = MaxBurst - 1;
          end else begin
            b_left--;
          end
          if (b_left == 0) b_owner = -1;
        end else begin
          b_owner = -1;
        end
        last_id = g;
      end
    end
    check("cpu_gnt", cpu_if.gnt, (g == 0));
    check("dma_gnt", dma_if.gnt, (g == 1));
    if (g >= 0) begin
      we = (g == 0) ? cpu_if.we : dma_if.we;
      a  = (g == 0) ? cpu_if.addr : dma_if.addr;
      d  = (g == 0) ? cpu_if.wdata : dma_if.wdata;
      m.stamp = cyc + 1; m.addr = a; m.we = we; m.wdata = d;
      mem_q.push_back(m);
      if (we == 4'd0) begin
        e.stamp = cyc + 2; e.id = g; e.data = ref_mem[a[5:0]];
        rd_q.push_back(e);
      end else begin
        ref_mem[a[5:0]] = merge(ref_mem[a[5:0]], d, we);
      end
    end
    last_gnt = g;
  endtask

  task automatic step();
    @(negedge clk);
    model_and_check();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int cycles);
    rst_n = 1'b0;
    mem_q.delete();
    rd_q.delete();
    for (int i = 0; i < 64; i++) ref_mem[i] = bram[i];
    repeat (cycles) step();
    rst_n = 1'b1;
  endtask

  // Monitor: match BRAM accesses and read returns against the scoreboard.
  mem_t mm;
  rd_t  ee;
  always @(negedge clk) begin
    if (mem_en) begin
      if (mem_q.size() == 0) begin
        check("mem_en_unexpected", 1, 0);
      end else begin
        mm = mem_q.pop_front();
        check("mem_stamp", cyc, mm.stamp);
        check("mem_addr", mem_addr, mm.addr);
        check("mem_we", mem_we, mm.we);
        check("mem_wdata", mem_wdata, mm.wdata);
      end
    end else begin
      check("mem_we_idle", mem_we, 0);
      if (mem_q.size() != 0 && mem_q[0].stamp <= cyc) begin
        check("mem_en_missing", 0, 1);
        void'(mem_q.pop_front());
      end
    end
    if (cpu_if.rvalid || dma_if.rvalid) begin
      check("rvalid_both", cpu_if.rvalid && dma_if.rvalid, 0);
      if (rd_q.size() == 0) begin
        check("rvalid_unexpected", 1, 0);
      end else begin
        ee = rd_q.pop_front();
        check("rd_stamp", cyc, ee.stamp);
        check("rd_id", dma_if.rvalid ? 1 : 0, ee.id);
        check("rd_data", (ee.id == 0) ? cpu_if.rdata : dma_if.rdata, ee.data);
        check("rd_other_zero", (ee.id == 0) ? dma_if.rdata : cpu_if.rdata, 0);
      end
    end else begin
      check("rdata_idle", {cpu_if.rdata, dma_if.rdata}, 0);
      if (rd_q.size() != 0 && rd_q[0].stamp <= cyc) begin
        check("rvalid_missing", 0, 1);
        void'(rd_q.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      bram[i]    = 32'h5a5a_0000 ^ (32'(i) * 32'h0101_0101);
      ref_mem[i] = bram[i];
    end
    bram[16]    = 32'hDEAD_BEEF;
    ref_mem[16] = 32'hDEAD_BEEF;
    rst_n = 1'b0;
    set_req(0, 0, 0, 4'd0, 14'd0, 32'd0);
    set_req(1, 0, 0, 4'd0, 14'd0, 32'd0);
    @(posedge clk);
    #1;
    do_reset(3);

    // Contention from reset: CPU first, then alternate
    set_req(0, 1, 0, 4'd0, 14'd3, 32'd0);
    set_req(1, 1, 0, 4'd0, 14'd5, 32'd0);
    step();
    check("first_contention_cpu", dut_g, 0);
    step();
    check("second_contention_dma", dut_g, 1);
    repeat (4) step();
    set_req(0, 0, 0, 4'd0, 14'd0, 32'd0);
    set_req(1, 0, 0, 4'd0, 14'd0, 32'd0);
    repeat (3) step();

    // Single CPU read of 0x10
    set_req(0, 1, 0, 4'd0, 14'h10, 32'd0);
    step();
    check("single_read_gnt", dut_g, 0);
    set_req(0, 0, 0, 4'd0, 14'd0, 32'd0);
    repeat (3) step();

    // DMA burst lock against a waiting CPU
    set_req(0, 1, 0, 4'd0, 14'd9, 32'd0);
    set_req(1, 1, 1, 4'd0, 14'd7, 32'd0);
    for (int k = 0; k < MaxBurst; k++) begin
      step();
      check("burst_dma_beat", dut_g, 1);
    end
    step();
    check("burst_release_cpu", dut_g, 0);
    repeat (3) step();
    set_req(0, 0, 0, 4'd0, 14'd0, 32'd0);
    set_req(1, 0, 0, 4'd0, 14'd0, 32'd0);
    repeat (2) step();

    // Lock drop after two beats
    set_req(1, 1, 1, 4'd0, 14'd11, 32'd0);
    repeat (2) step();
    set_req(1, 0, 0, 4'd0, 14'd0, 32'd0);
    set_req(0, 1, 0, 4'd0, 14'd12, 32'd0);
    step();
    check("lock_drop_cpu", dut_g, 0);
    set_req(1, 1, 0, 4'd0, 14'd13, 32'd0);
    step();
    check("lock_cleared_rr", dut_g, 1);
    set_req(0, 0, 0, 4'd0, 14'd0, 32'd0);
    set_req(1, 0, 0, 4'd0, 14'd0, 32'd0);
    repeat (2) step();

    // Byte-lane write, then read it back
    set_req(0, 1, 0, 4'b0100, 14'h20, 32'hABAB_ABAB);
    step();
    set_req(0, 1, 0, 4'd0, 14'h20, 32'd0);
    step();
    set_req(0, 0, 0, 4'd0, 14'd0, 32'd0);
    repeat (3) step();

    // Reset while a read is in flight
    set_req(0, 1, 0, 4'd0, 14'h10, 32'd0);
    step();
    set_req(1, 1, 0, 4'd0, 14'd2, 32'd0);
    do_reset(2);
    step();
    check("post_reset_cpu", dut_g, 0);
    step();
    set_req(0, 0, 0, 4'd0, 14'd0, 32'd0);
    set_req(1, 0, 0, 4'd0, 14'd0, 32'd0);
    repeat (4) step();

    // Random traffic; a requester holds its payload until granted
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (last_gnt == i || !((i == 0) ? cpu_if.req : dma_if.req)) rand_req(i);
      end
      step();
    end

    set_req(0, 0, 0, 4'd0, 14'd0, 32'd0);
    set_req(1, 0, 0, 4'd0, 14'd0, 32'd0);
    repeat (5) step();
    check("mem_q_drained", mem_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
